// File: rtl/commit_store_drain_if.sv
// commit_store_drain_if: commit/drain control and D-cache store write port bundle
interface commit_store_drain_if #(parameter int SIZE_LSQ_LOG = 5);
  logic [2:0]              commit_cnt;
  logic                    drain_req;
  logic                    dc_wr_ready;
  logic                    st_wr_valid;
  logic [SIZE_LSQ_LOG-1:0] st_wr_index;
  logic [SIZE_LSQ_LOG-1:0] commit_ptr;
  logic [SIZE_LSQ_LOG-1:0] head_ptr;
  logic [SIZE_LSQ_LOG:0]   pending;
  logic                    commit_stall;
  logic                    drain_done;
  logic                    overflow_err;
  modport master (
    output commit_cnt, drain_req, dc_wr_ready,
    input  st_wr_valid, st_wr_index, commit_ptr, head_ptr, pending,
           commit_stall, drain_done, overflow_err
  );
  modport slave (
    input  commit_cnt, drain_req, dc_wr_ready,
    output st_wr_valid, st_wr_index, commit_ptr, head_ptr, pending,
           commit_stall, drain_done, overflow_err
  );
endinterface

// File: rtl/commit_store_drain.sv
// commit_store_drain: drains committed stores into the D-cache write port, with stall and fence control
module commit_store_drain #(
  parameter int SIZE_LSQ_LOG = 5,
  parameter int STALL_THRESH = 29
) (
  input logic clk,
  input logic reset,
  commit_store_drain_if.slave bus
);
  localparam int W = SIZE_LSQ_LOG;
  localparam int N = 1 << W;
  typedef enum logic [1:0] {IDLE, DRAIN, FENCE, DONE} state_t;
  state_t       state, state_nx;
  logic [W-1:0] commit_ptr, head_ptr;
  logic [W:0]   pending, pend_nx;
  logic [W+1:0] sum;
  logic [2:0]   cnt;
  logic         bad, fire, ovf, stall, err;
  always_comb begin
    bad     = bus.commit_cnt > 3'd4;
    cnt     = bad ? 3'd0 : bus.commit_cnt;
    fire    = (pending != '0) & bus.dc_wr_ready;
    sum     = {1'b0, pending} + (W+2)'(cnt) - (W+2)'(fire);
    ovf     = sum > (W+2)'(N);
    pend_nx = ovf ? (W+1)'(N) : sum[W:0];
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  // A fence, once entered, runs to completion regardless of drain_req
  always_comb begin
    state_nx = state == DONE  ? IDLE :
               state == FENCE ? (pend_nx == '0 ? DONE : FENCE) :
               bus.drain_req  ? ((state == IDLE && pend_nx == '0) ? DONE : FENCE) :
                                (pend_nx == '0 ? IDLE : DRAIN);
  end
  always_ff @(posedge clk)
    if (reset) begin
      commit_ptr <= '0;
      head_ptr   <= '0;
      pending    <= '0;
      stall      <= 1'b0;
      err        <= 1'b0;
    end else begin
      commit_ptr <= commit_ptr + W'(cnt);
      head_ptr   <= head_ptr + W'(fire);
      pending    <= pend_nx;
      stall      <= pend_nx >= (W+1)'(STALL_THRESH) || state_nx == FENCE;
      err        <= err | bad | ovf;
    end
  always_comb begin
    bus.st_wr_valid  = pending != '0;
    bus.st_wr_index  = head_ptr;
    bus.commit_ptr   = commit_ptr;
    bus.head_ptr     = head_ptr;
    bus.pending      = pending;
    bus.commit_stall = stall;
    bus.drain_done   = state == DONE;
    bus.overflow_err = err;
  end
endmodule
